// File: rtl/world_pkg.sv
// Shared types for the world memory: command and status codes plus the entry layout
// that both world_writer and world_drawer use.
package world_pkg;

    localparam int COORD_WIDTH = 32;
    localparam int FIELD_WIDTH = COORD_WIDTH / 2;
    localparam int ENTRY_WIDTH = 3 * COORD_WIDTH / 2 + 1;

    typedef enum logic [1:0] {
        OP_PLACE  = 2'd0,
        OP_REMOVE = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_QUERY  = 2'd3
    } world_op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_EXISTS    = 2'd1,
        ST_FULL      = 2'd2,
        ST_NOT_FOUND = 2'd3
    } world_status_t;

    // z sits in the LSBs, valid in the MSB.
    typedef struct packed {
        logic                   valid;
        logic [FIELD_WIDTH-1:0] x;
        logic [FIELD_WIDTH-1:0] y;
        logic [FIELD_WIDTH-1:0] z;
    } world_entry_t;

endpackage

// File: rtl/world_writer_if.sv
// Command/status bus between the game logic (master) and world_writer (slave).
interface world_writer_if #(
    parameter int WORLD_BITS = 7
);
    import world_pkg::*;

    logic                          cmd_valid;
    logic                          cmd_ready;
    world_op_t                     cmd_op;
    logic signed [FIELD_WIDTH-1:0] cmd_x;
    logic signed [FIELD_WIDTH-1:0] cmd_y;
    logic signed [FIELD_WIDTH-1:0] cmd_z;
    logic                          busy;
    logic                          done;
    world_status_t                 status;
    logic [WORLD_BITS-1:0]         status_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z,
        input  cmd_ready, busy, done, status, status_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_z,
        output cmd_ready, busy, done, status, status_addr
    );

endinterface

// File: rtl/world_scan_ctrl.sv
// Address walker for readers that scan the world memory: holds each address for the
// memory read latency, flags the last entry, and can jump to a write-back target.
module world_scan_ctrl #(
    parameter int WORLD_SIZE   = 100,
    parameter int WORLD_BITS   = 7,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_i,      // restart at entry 0
    input  logic                  wait_i,       // a wait cycle for the current entry elapsed
    input  logic                  next_i,       // advance one entry, saturating at the last
    input  logic                  load_i,       // jump to load_addr_i
    input  logic [WORLD_BITS-1:0] load_addr_i,
    output logic [WORLD_BITS-1:0] addr_o,
    output logic                  wait_done_o,  // final wait cycle for the current entry
    output logic                  last_o        // current entry is WORLD_SIZE-1
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0]      WAIT_MAX  = CNT_W'(READ_LATENCY - 1);
    localparam logic [WORLD_BITS-1:0] LAST_ADDR = WORLD_BITS'(WORLD_SIZE - 1);

    logic [WORLD_BITS-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign addr_o      = addr_q;
    assign wait_done_o = (cnt_q == WAIT_MAX);
    assign last_o      = (addr_q == LAST_ADDR);

    // Next address / wait count.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            addr_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            addr_d = load_addr_i;
        end else if (next_i) begin
            if (!last_o) addr_d = addr_q + WORLD_BITS'(1);
            cnt_d = '0;
        end else if (wait_i && !wait_done_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk_in) begin
        // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on the edge.
        if (rst_in) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/world_writer.sv
// world_writer: owns the world memory write port; places, removes, queries and clears
// cube entries by scanning the memory one entry at a time.
module world_writer
    import world_pkg::*;
#(
    parameter int WORLD_SIZE   = 100,
    parameter int WORLD_BITS   = 7,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   lock_in,
    world_writer_if.slave          cmd,
    input  logic [ENTRY_WIDTH-1:0] world_read,
    output logic [WORLD_BITS-1:0]  world_addr,
    output logic [ENTRY_WIDTH-1:0] world_write_data,
    output logic                   world_we
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN_WAIT, S_SCAN_CMP, S_WRITE, S_CLEAR, S_DONE
    } state_t;

    localparam logic [WORLD_BITS-1:0] LAST_ADDR = WORLD_BITS'(WORLD_SIZE - 1);

    state_t                state_q, state_d;
    world_op_t             op_q, op_d;
    world_entry_t          key_q, key_d;         // latched coordinates, valid preset to 1
    logic                  free_found_q, free_found_d;
    logic [WORLD_BITS-1:0] first_free_q, first_free_d;
    world_entry_t          wdata_q, wdata_d;
    world_status_t         status_q, status_d;
    logic [WORLD_BITS-1:0] status_addr_q, status_addr_d;

    logic                  scan_start, scan_wait, scan_next, scan_load;
    logic [WORLD_BITS-1:0] scan_load_addr, scan_addr;
    logic                  scan_wait_done, scan_last;

    world_entry_t          rd_entry;
    logic                  hit;
    logic                  accept;
    logic [WORLD_BITS-1:0] place_addr;

    world_scan_ctrl #(
        .WORLD_SIZE  (WORLD_SIZE),
        .WORLD_BITS  (WORLD_BITS),
        .READ_LATENCY(READ_LATENCY)
    ) u_scan (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_i    (scan_start),
        .wait_i     (scan_wait),
        .next_i     (scan_next),
        .load_i     (scan_load),
        .load_addr_i(scan_load_addr),
        .addr_o     (scan_addr),
        .wait_done_o(scan_wait_done),
        .last_o     (scan_last)
    );

    assign rd_entry   = world_entry_t'(world_read);
    assign hit        = rd_entry.valid && (rd_entry.x == key_q.x)
                        && (rd_entry.y == key_q.y) && (rd_entry.z == key_q.z);
    // The slot a PLACE lands in: the earliest free entry, or the last one if it is the first free.
    assign place_addr = free_found_q ? first_free_q : scan_addr;

    assign cmd.cmd_ready   = (state_q == S_IDLE) && !lock_in && !rst_in;
    assign accept          = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd.busy        = (state_q != S_IDLE);
    assign cmd.done        = (state_q == S_DONE);
    assign cmd.status      = status_q;
    assign cmd.status_addr = status_addr_q;

    // A write presented while reset is high still lands; reset only stops the next one.
    assign world_we         = (state_q == S_WRITE) || (state_q == S_CLEAR);
    assign world_addr       = scan_addr;
    assign world_write_data = wdata_q;

    // Next-state, scan control and result decisions.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        key_d          = key_q;
        free_found_d   = free_found_q;
        first_free_d   = first_free_q;
        wdata_d        = wdata_q;
        status_d       = status_q;
        status_addr_d  = status_addr_q;
        scan_start     = 1'b0;
        scan_wait      = 1'b0;
        scan_next      = 1'b0;
        scan_load      = 1'b0;
        scan_load_addr = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d         = cmd.cmd_op;
                    key_d.valid  = 1'b1;
                    key_d.x      = cmd.cmd_x;
                    key_d.y      = cmd.cmd_y;
                    key_d.z      = cmd.cmd_z;
                    free_found_d = 1'b0;
                    first_free_d = '0;
                    wdata_d      = '0;
                    scan_start   = 1'b1;
                    state_d      = (cmd.cmd_op == OP_CLEAR) ? S_CLEAR : S_SCAN_WAIT;
                end
            end
            S_SCAN_WAIT: begin
                scan_wait = 1'b1;
                if (scan_wait_done) state_d = S_SCAN_CMP;
            end
            S_SCAN_CMP: begin
                if (!rd_entry.valid && !free_found_q) begin
                    free_found_d = 1'b1;
                    first_free_d = scan_addr;
                end
                if (hit) begin
                    status_addr_d = scan_addr;
                    if (op_q == OP_REMOVE) begin
                        wdata_d  = '0;
                        status_d = ST_OK;
                        state_d  = S_WRITE;
                    end else begin
                        status_d = ST_EXISTS;
                        state_d  = S_DONE;
                    end
                end else if (scan_last) begin
                    if (op_q == OP_PLACE && (free_found_q || !rd_entry.valid)) begin
                        scan_load      = 1'b1;
                        scan_load_addr = place_addr;
                        wdata_d        = key_q;
                        status_d       = ST_OK;
                        status_addr_d  = place_addr;
                        state_d        = S_WRITE;
                    end else begin
                        status_d      = (op_q == OP_PLACE) ? ST_FULL : ST_NOT_FOUND;
                        status_addr_d = '0;
                        state_d       = S_DONE;
                    end
                end else begin
                    scan_next = 1'b1;
                    state_d   = S_SCAN_WAIT;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_CLEAR: begin
                if (scan_last) begin
                    status_d      = ST_OK;
                    status_addr_d = LAST_ADDR;
                    state_d       = S_DONE;
                end else begin
                    scan_next = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            op_q          <= OP_PLACE;
            key_q         <= '0;
            free_found_q  <= 1'b0;
            first_free_q  <= '0;
            wdata_q       <= '0;
            status_q      <= ST_OK;
            status_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            key_q         <= key_d;
            free_found_q  <= free_found_d;
            first_free_q  <= first_free_d;
            wdata_q       <= wdata_d;
            status_q      <= status_d;
            status_addr_q <= status_addr_d;
        end
    end

endmodule

// File: tb/tb_world_writer.sv
// Bench for world_writer: 4-entry world memory with a 2-cycle read, directed commands,
// and a model that predicts result, write cycles and done cycle from the scan-time rules.
module tb_world_writer;
    import world_pkg::*;

    localparam int WS  = 4;
    localparam int WB  = 2;
    localparam int RL  = 2;
    localparam int PER = RL + 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   lock = 1'b0;
    logic [ENTRY_WIDTH-1:0] world_read;
    logic [ENTRY_WIDTH-1:0] world_write_data;
    logic [WB-1:0]          world_addr;
    logic                   world_we;

    world_writer_if #(.WORLD_BITS(WB)) bus ();

    world_writer #(
        .WORLD_SIZE  (WS),
        .WORLD_BITS  (WB),
        .READ_LATENCY(RL)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .lock_in         (lock),
        .cmd             (bus),
        .world_read      (world_read),
        .world_addr      (world_addr),
        .world_write_data(world_write_data),
        .world_we        (world_we)
    );

    always #5 clk = ~clk;

    // World memory: 2-cycle registered read, single write port, bulk preload.
    world_entry_t mem [WS];
    world_entry_t preload [WS];
    logic         load_req = 1'b0;
    world_entry_t rd1, rd2;

    always @(posedge clk) begin
        if (load_req) mem <= preload;
        else if (world_we) mem[world_addr] <= world_entry_t'(world_write_data);
        rd1 <= mem[world_addr];
        rd2 <= rd1;
    end
    assign world_read = rd2;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic world_entry_t ent(input logic v, input logic [15:0] x, y, z);
        world_entry_t e;
        e.valid = v; e.x = x; e.y = y; e.z = z;
        return e;
    endfunction

    // Model state: expected memory contents and the prediction for the current command.
    world_entry_t  shadow [WS];
    world_status_t exp_status;
    int            exp_saddr, exp_done, exp_wr_first, exp_wr_count, exp_wr_addr0;
    world_entry_t  exp_wr_data;

    task automatic model(input world_op_t op, input logic [15:0] x, y, z);
        int match, free;
        world_entry_t key;
        match = -1; free = -1;
        key = ent(1'b1, x, y, z);
        for (int i = 0; i < WS; i++) begin
            if (match < 0 && shadow[i] == key) match = i;
            if (free < 0 && !shadow[i].valid) free = i;
        end
        exp_wr_count = 0; exp_wr_first = 0; exp_wr_addr0 = 0; exp_wr_data = '0;
        exp_saddr = 0;
        case (op)
            OP_CLEAR: begin
                exp_wr_first = 1; exp_wr_count = WS;
                exp_done = WS + 1; exp_status = ST_OK; exp_saddr = WS - 1;
                for (int i = 0; i < WS; i++) shadow[i] = '0;
            end
            OP_PLACE: begin
                if (match >= 0) begin
                    exp_done = (match + 1) * PER + 1; exp_status = ST_EXISTS; exp_saddr = match;
                end else if (free >= 0) begin
                    exp_wr_first = WS * PER + 1; exp_wr_count = 1;
                    exp_wr_addr0 = free; exp_wr_data = key;
                    exp_done = WS * PER + 2; exp_status = ST_OK; exp_saddr = free;
                    shadow[free] = key;
                end else begin
                    exp_done = WS * PER + 1; exp_status = ST_FULL;
                end
            end
            OP_REMOVE: begin
                if (match >= 0) begin
                    exp_wr_first = (match + 1) * PER + 1; exp_wr_count = 1;
                    exp_wr_addr0 = match;
                    exp_done = exp_wr_first + 1; exp_status = ST_OK; exp_saddr = match;
                    shadow[match] = '0;
                end else begin
                    exp_done = WS * PER + 1; exp_status = ST_NOT_FOUND;
                end
            end
            default: begin
                if (match >= 0) begin
                    exp_done = (match + 1) * PER + 1; exp_status = ST_EXISTS; exp_saddr = match;
                end else begin
                    exp_done = WS * PER + 1; exp_status = ST_NOT_FOUND;
                end
            end
        endcase
    endtask

    task automatic load_mem(input world_entry_t e0, e1, e2, e3);
        preload[0] = e0; preload[1] = e1; preload[2] = e2; preload[3] = e3;
        shadow[0]  = e0; shadow[1]  = e1; shadow[2]  = e2; shadow[3]  = e3;
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < WS; i++)
            check($sformatf("%s mem[%0d]", tag, i), 64'(mem[i]), 64'(shadow[i]));
    endtask

    // Issues one command and compares every output on every cycle until it is idle again.
    task automatic run_cmd(input string tag, input world_op_t op, input logic [15:0] x, y, z,
                           input bit hold, input bit lock_mid, output int seen_done);
        bit in_we;
        model(op, x, y, z);
        seen_done = 0;
        @(negedge clk);
        check({tag, " ready before accept"}, 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_x = x; bus.cmd_y = y; bus.cmd_z = z;
        for (int n = 1; n <= exp_done + 1; n++) begin
            @(negedge clk);
            in_we = (n >= exp_wr_first) && (n < exp_wr_first + exp_wr_count);
            check($sformatf("%s busy@%0d", tag, n), 64'(bus.busy), 64'(n <= exp_done));
            check($sformatf("%s done@%0d", tag, n), 64'(bus.done), 64'(n == exp_done));
            check($sformatf("%s we@%0d", tag, n), 64'(world_we), 64'(in_we));
            check($sformatf("%s ready@%0d", tag, n), 64'(bus.cmd_ready),
                  64'((n > exp_done) && !lock));
            if (in_we) begin
                check($sformatf("%s waddr@%0d", tag, n), 64'(world_addr),
                      64'(exp_wr_addr0 + n - exp_wr_first));
                check($sformatf("%s wdata@%0d", tag, n), 64'(world_write_data), 64'(exp_wr_data));
            end
            if (n == exp_done) begin
                check({tag, " status"}, 64'(bus.status), 64'(exp_status));
                check({tag, " status_addr"}, 64'(bus.status_addr), 64'(exp_saddr));
            end
            if (bus.done) seen_done = n;
            if (!hold || n >= exp_done) bus.cmd_valid = 1'b0;
            if (hold && n == 1) begin
                bus.cmd_x = ~x; bus.cmd_y = ~y; bus.cmd_z = ~z;
                bus.cmd_op = (op == OP_CLEAR) ? OP_PLACE : OP_CLEAR;
            end
            if (lock_mid && n == 2) lock = 1'b1;
        end
        lock = 1'b0;
    endtask

    initial begin
        int seen;
        int we_seen;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_PLACE;
        bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_z = '0;
        load_mem('0, '0, '0, '0);
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst we", 64'(world_we), 64'(0));
        check("rst addr", 64'(world_addr), 64'(0));
        check("rst wdata", 64'(world_write_data), 64'(0));
        check("rst busy", 64'(bus.busy), 64'(0));
        check("rst done", 64'(bus.done), 64'(0));
        check("rst status", 64'(bus.status), 64'(ST_OK));
        check("rst status_addr", 64'(bus.status_addr), 64'(0));
        check("rst ready low", 64'(bus.cmd_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready after rst", 64'(bus.cmd_ready), 64'(1));

        // Empty memory, PLACE lands in entry 0 after a full scan.
        run_cmd("place_empty", OP_PLACE, 16'h0003, 16'hFFFE, 16'h0007, 1'b0, 1'b0, seen);
        check("place_empty done cycle", 64'(seen), 64'(14));
        check("place_empty mem0", 64'(mem[0]), 64'h1_0003_FFFE_0007);
        check_mem("place_empty");

        // Match at entry 2; entry 1 holds the same coords but is not valid.
        load_mem(ent(1, 16'h1, 16'h1, 16'h1), ent(0, 16'h10, 16'h20, 16'h30),
                 ent(1, 16'h10, 16'h20, 16'h30), '0);
        run_cmd("place_exists", OP_PLACE, 16'h10, 16'h20, 16'h30, 1'b0, 1'b0, seen);
        check("place_exists done cycle", 64'(seen), 64'(10));
        check("place_exists status", 64'(bus.status), 64'(ST_EXISTS));
        check("place_exists addr", 64'(bus.status_addr), 64'(2));
        run_cmd("query_hit0", OP_QUERY, 16'h1, 16'h1, 16'h1, 1'b0, 1'b0, seen);
        check("query_hit0 done cycle", 64'(seen), 64'(4));
        check_mem("exists");

        // Full memory, one entry differs only in z.
        load_mem(ent(1, 16'h77, 16'h78, 16'h00), ent(1, 16'h1, 16'h2, 16'h3),
                 ent(1, 16'h4, 16'h5, 16'h6), ent(1, 16'h7, 16'h8, 16'h9));
        run_cmd("place_full", OP_PLACE, 16'h77, 16'h78, 16'h79, 1'b0, 1'b0, seen);
        check("place_full done cycle", 64'(seen), 64'(13));
        check("place_full status", 64'(bus.status), 64'(ST_FULL));
        check_mem("full");

        // Two free slots: the first one wins; inputs scrambled while busy.
        load_mem(ent(1, 16'h1, 16'h1, 16'h1), '0, ent(1, 16'h2, 16'h2, 16'h2), '0);
        run_cmd("place_first_free", OP_PLACE, 16'h40, 16'h41, 16'h42, 1'b1, 1'b0, seen);
        check("place_first_free mem1", 64'(mem[1]), 64'h1_0040_0041_0042);
        check("place_first_free addr", 64'(bus.status_addr), 64'(1));
        check_mem("first_free");

        // Only the last entry is free.
        load_mem(ent(1, 16'h1, 16'h1, 16'h1), ent(1, 16'h2, 16'h2, 16'h2),
                 ent(1, 16'h3, 16'h3, 16'h3), '0);
        run_cmd("place_last", OP_PLACE, 16'h9, 16'h8, 16'h7, 1'b0, 1'b0, seen);
        check("place_last addr", 64'(bus.status_addr), 64'(3));
        check_mem("place_last");

        // REMOVE with lock raised mid-operation, then QUERY misses.
        load_mem('0, ent(1, 16'h5, 16'h5, 16'h5), '0, '0);
        run_cmd("remove", OP_REMOVE, 16'h5, 16'h5, 16'h5, 1'b0, 1'b1, seen);
        check("remove done cycle", 64'(seen), 64'(8));
        check("remove addr", 64'(bus.status_addr), 64'(1));
        check("remove mem1", 64'(mem[1]), 64'(0));
        run_cmd("query_miss", OP_QUERY, 16'h5, 16'h5, 16'h5, 1'b0, 1'b0, seen);
        check("query_miss status", 64'(bus.status), 64'(ST_NOT_FOUND));
        check("query_miss done cycle", 64'(seen), 64'(13));

        // CLEAR wipes a populated memory.
        load_mem(ent(1, 16'h1, 16'h1, 16'h1), ent(1, 16'h2, 16'h2, 16'h2),
                 ent(1, 16'h3, 16'h3, 16'h3), ent(1, 16'h4, 16'h4, 16'h4));
        run_cmd("clear", OP_CLEAR, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, seen);
        check("clear done cycle", 64'(seen), 64'(5));
        check("clear addr", 64'(bus.status_addr), 64'(3));
        check_mem("clear");

        // Reset during SCAN_WAIT of a PLACE aborts without a write.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_PLACE;
        bus.cmd_x = 16'h9; bus.cmd_y = 16'h9; bus.cmd_z = 16'h9;
        @(negedge clk);
        check("abort busy before rst", 64'(bus.busy), 64'(1));
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort we", 64'(world_we), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("abort ready", 64'(bus.cmd_ready), 64'(1));
        we_seen = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (world_we) we_seen++;
        end
        check("abort no writes", 64'(we_seen), 64'(0));
        check("abort status", 64'(bus.status), 64'(ST_OK));
        check_mem("abort");

        // lock_in blocks accept while cmd_valid is held.
        model(OP_QUERY, 16'h1, 16'h2, 16'h3);
        @(negedge clk);
        lock = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_QUERY;
        bus.cmd_x = 16'h1; bus.cmd_y = 16'h2; bus.cmd_z = 16'h3;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check($sformatf("lock ready@%0d", n), 64'(bus.cmd_ready), 64'(0));
            check($sformatf("lock busy@%0d", n), 64'(bus.busy), 64'(0));
        end
        lock = 1'b0;
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("lock released busy", 64'(bus.busy), 64'(1));
                bus.cmd_valid = 1'b0;
            end
            if (bus.done) begin
                seen = n;
                break;
            end
        end
        check("lock done cycle", 64'(seen), 64'(exp_done));
        check("lock status", 64'(bus.status), 64'(exp_status));
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
